// File: rtl/ram_bist_master.sv
// BIST initiator for the small register-file RAM.
// Runs four passes: write P, read/compare P, write ~P, read/compare ~P. P(a) = seed ^ a.
module ram_bist_master #(
    parameter int unsigned ADDR_W = 1,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WR1  = 3'd1;
    localparam logic [2:0] RD1  = 3'd2;
    localparam logic [2:0] WR2  = 3'd3;
    localparam logic [2:0] RD2  = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_W-1:0] fail_got_q, fail_got_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [DATA_W-1:0] exp_data;

    function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                  input logic [ADDR_W-1:0] a,
                                                  input logic              inv);
        logic [DATA_W-1:0] p;
        p = s ^ DATA_W'(a);
        return inv ? ~p : p;
    endfunction

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        seed_d      = seed_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;
        err_d       = err_q;
        exp_data    = pattern(seed_q, addr_q, state_q == RD2);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = WR1;
                    addr_d      = '0;
                    seed_d      = seed;
                    wdata_d     = pattern(seed, '0, 1'b0);
                    we_d        = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_got_d  = '0;
                    err_d       = '0;
                end
            end
            WR1, RD1, WR2, RD2: begin
                addr_d = addr_q + 1'b1;
                if ((state_q == RD1 || state_q == RD2) && mem_q != exp_data) begin
                    // Saturated count never returns to zero, so zero marks the first mismatch.
                    if (err_q == '0) begin
                        fail_addr_d = addr_q;
                        fail_exp_d  = exp_data;
                        fail_got_d  = mem_q;
                    end
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                end
                if (addr_q == ADDR_LAST) begin
                    case (state_q)
                        WR1:     state_d = RD1;
                        RD1:     state_d = WR2;
                        WR2:     state_d = RD2;
                        default: state_d = DONE;
                    endcase
                end
                if (state_d == DONE) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                    we_d    = 1'b0;
                    wdata_d = '0;
                end else begin
                    we_d    = (state_d == WR1) || (state_d == WR2);
                    wdata_d = we_d ? pattern(seed_q, addr_d, state_d == WR2) : '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            seed_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_got_q  <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            seed_q      <= seed_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_got_q  <= fail_got_d;
            err_q       <= err_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_d     = wdata_q;
    assign mem_we    = we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_exp  = fail_exp_q;
    assign fail_got  = fail_got_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_ram_bist_master.sv
// Bench for ram_bist_master: two instances (2-word and 8-word) each driving a faulty-RAM model.
module tb_ram_bist_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic [3:0] seed_tb = 4'h0;

    logic [0:0] addr_a;  logic [3:0] d_a;  logic we_a;  logic [3:0] q_a;
    logic busy_a, done_a, pass_a;
    logic [0:0] fa_a;  logic [3:0] fe_a, fg_a;  logic [7:0] err_a;

    logic [2:0] addr_b;  logic [3:0] d_b;  logic we_b;  logic [3:0] q_b;
    logic busy_b, done_b, pass_b;
    logic [2:0] fa_b;  logic [3:0] fe_b, fg_b;  logic [1:0] err_b;

    // Read fault model: returned word = (stored & and_m) | or_m
    logic [3:0] and_m [8];
    logic [3:0] or_m  [8];
    logic [3:0] mem_a [2];
    logic [3:0] mem_b [8];

    int total = 0;
    int bad = 0;

    logic ob_busy, ob_done, ob_pass, ob_we;
    int ob_addr, ob_fa, ob_err;
    logic [3:0] ob_d, ob_fe, ob_fg;

    always #5 clk = ~clk;

    ram_bist_master #(.ADDR_W(1), .DATA_W(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .seed(seed_tb),
        .mem_addr(addr_a), .mem_d(d_a), .mem_we(we_a), .mem_q(q_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_addr(fa_a), .fail_exp(fe_a), .fail_got(fg_a), .err_count(err_a)
    );

    ram_bist_master #(.ADDR_W(3), .DATA_W(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .seed(seed_tb),
        .mem_addr(addr_b), .mem_d(d_b), .mem_we(we_b), .mem_q(q_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_addr(fa_b), .fail_exp(fe_b), .fail_got(fg_b), .err_count(err_b)
    );

    always @(posedge clk) begin
        if (we_a) mem_a[addr_a] <= d_a;
        if (we_b) mem_b[addr_b] <= d_b;
    end

    assign q_a = (mem_a[addr_a] & and_m[{2'b00, addr_a}]) | or_m[{2'b00, addr_a}];
    assign q_b = (mem_b[addr_b] & and_m[addr_b]) | or_m[addr_b];

    task automatic clear_masks();
        for (int i = 0; i < 8; i++) begin
            and_m[i] = 4'hF;
            or_m[i]  = 4'h0;
        end
    endtask

    task automatic sample(input int which);
        if (which == 0) begin
            ob_busy = busy_a; ob_done = done_a; ob_pass = pass_a; ob_we = we_a;
            ob_addr = int'(addr_a); ob_d = d_a; ob_fa = int'(fa_a); ob_fe = fe_a;
            ob_fg = fg_a; ob_err = int'(err_a);
        end else begin
            ob_busy = busy_b; ob_done = done_b; ob_pass = pass_b; ob_we = we_b;
            ob_addr = int'(addr_b); ob_d = d_b; ob_fa = int'(fa_b); ob_fe = fe_b;
            ob_fg = fg_b; ob_err = int'(err_b);
        end
    endtask

    // Reference: walk both compare passes over the words the fault model returns.
    task automatic ref_run(input logic [3:0] s, input int n, input int cmax, output int e,
                           output bit p, output int fa, output logic [3:0] fe,
                           output logic [3:0] fg);
        logic [3:0] w, r;
        e = 0; p = 1'b1; fa = 0; fe = 4'h0; fg = 4'h0;
        for (int inv = 0; inv < 2; inv++) begin
            for (int a = 0; a < n; a++) begin
                w = s ^ 4'(a);
                if (inv != 0) w = ~w;
                r = (w & and_m[a]) | or_m[a];
                if (r != w) begin
                    if (p) begin fa = a; fe = w; fg = r; end
                    p = 1'b0;
                    if (e < cmax) e++;
                end
            end
        end
    endtask

    // Must be called at a negedge; raises start and checks the whole run.
    task automatic run(input int which, input logic [3:0] s, input bit hold, input string tag);
        int n, cmax, e, fa, serr, ph, a;
        bit p;
        logic [3:0] fe, fg, wd;
        n = (which == 0) ? 2 : 8;
        cmax = (which == 0) ? 255 : 3;
        ref_run(s, n, cmax, e, p, fa, fe, fg);
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        seed_tb = s;
        serr = 0;
        for (int k = 1; k <= 4 * n; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) begin start_a = 1'b0; start_b = 1'b0; end
            if (k == 2) seed_tb = 4'($urandom);
            sample(which);
            ph = (k - 1) / n;
            a = (k - 1) % n;
            wd = s ^ 4'(a) ^ ((ph == 2) ? 4'hF : 4'h0);
            if (ob_busy !== 1'b1 || ob_done !== 1'b0 || ob_addr != a
                || ob_we !== (ph == 0 || ph == 2) || (ob_we === 1'b1 && ob_d !== wd))
                serr++;
        end
        total++;
        if (serr != 0) begin
            bad++; $display("FAIL %s stream: got %0d bad cycles, want 0", tag, serr);
        end
        @(negedge clk);
        sample(which);
        total++; if (ob_busy !== 1'b0) begin bad++; $display("FAIL %s busy_end: got %b want 0", tag, ob_busy); end
        total++; if (ob_done !== 1'b1) begin bad++; $display("FAIL %s done: got %b want 1", tag, ob_done); end
        total++; if (ob_pass !== p) begin bad++; $display("FAIL %s pass: got %b want %b", tag, ob_pass, p); end
        total++; if (ob_err != e) begin bad++; $display("FAIL %s err_count: got %0d want %0d", tag, ob_err, e); end
        total++; if (ob_fa != fa) begin bad++; $display("FAIL %s fail_addr: got %0d want %0d", tag, ob_fa, fa); end
        total++; if (ob_fe !== fe) begin bad++; $display("FAIL %s fail_exp: got %h want %h", tag, ob_fe, fe); end
        total++; if (ob_fg !== fg) begin bad++; $display("FAIL %s fail_got: got %h want %h", tag, ob_fg, fg); end
        total++;
        if (ob_we !== 1'b0 || ob_addr != 0 || ob_d !== 4'h0) begin
            bad++; $display("FAIL %s mem_idle: got we=%b addr=%0d d=%h want 0/0/0", tag, ob_we, ob_addr, ob_d);
        end
    endtask

    task automatic check_zero(input int which, input string tag);
        sample(which);
        total++;
        if (ob_busy !== 1'b0 || ob_done !== 1'b0 || ob_pass !== 1'b0 || ob_we !== 1'b0
            || ob_addr != 0 || ob_d !== 4'h0 || ob_fa != 0 || ob_fe !== 4'h0
            || ob_fg !== 4'h0 || ob_err != 0) begin
            bad++;
            $display("FAIL %s: got busy=%b done=%b pass=%b we=%b addr=%0d d=%h fa=%0d fe=%h fg=%h err=%0d want all 0",
                     tag, ob_busy, ob_done, ob_pass, ob_we, ob_addr, ob_d, ob_fa, ob_fe, ob_fg, ob_err);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        check_zero(0, "reset_a");
        check_zero(1, "reset_b");
        rst = 1'b0;
        @(negedge clk);
        check_zero(0, "reset_idle_a");
    endtask

    task automatic test_clean();
        clear_masks();
        run(0, 4'hA, 1'b0, "clean_A");
        for (int i = 0; i < 4; i++) run(0, 4'($urandom), 1'b0, "clean_rand");
    endtask

    task automatic test_stuck_bit();
        clear_masks();
        or_m[1] = 4'h1;
        run(0, 4'hA, 1'b0, "stuck_bit");
    endtask

    task automatic test_stuck_word();
        clear_masks();
        and_m[0] = 4'h0;
        run(0, 4'h0, 1'b0, "stuck_word_s0");
        run(0, 4'h3, 1'b0, "stuck_word_s3");
    endtask

    task automatic test_hold_start();
        clear_masks();
        or_m[0] = 4'h8;
        run(0, 4'h5, 1'b1, "hold_1");
        run(0, 4'h5, 1'b1, "hold_2");
        start_a = 1'b0;
        @(negedge clk);
        sample(0);
        total++;
        if (ob_done !== 1'b1 || ob_busy !== 1'b0) begin
            bad++; $display("FAIL hold_stop: got done=%b busy=%b want 1/0", ob_done, ob_busy);
        end
    endtask

    task automatic test_async_reset();
        clear_masks();
        start_a = 1'b1;
        seed_tb = 4'h6;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) start_a = 1'b0;
        end
        // Now in the first RD1 cycle; assert reset away from any clock edge.
        #1 rst = 1'b1;
        #1 check_zero(0, "async_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(0, 4'h6, 1'b0, "after_reset");
    endtask

    task automatic test_random_faults();
        for (int i = 0; i < 6; i++) begin
            clear_masks();
            for (int a = 0; a < 2; a++) begin
                if ($urandom_range(1, 0) == 1) begin
                    and_m[a] = 4'($urandom);
                    or_m[a]  = 4'($urandom);
                end
            end
            run(0, 4'($urandom), 1'b0, "rand_a");
        end
    endtask

    task automatic test_wide();
        clear_masks();
        for (int a = 0; a < 8; a++) and_m[a] = 4'h0;
        run(1, 4'h1, 1'b0, "wide_allbad");
        for (int i = 0; i < 3; i++) begin
            clear_masks();
            for (int a = 0; a < 8; a++) begin
                if ($urandom_range(3, 0) == 0) begin
                    and_m[a] = 4'($urandom);
                    or_m[a]  = 4'($urandom);
                end
            end
            run(1, 4'($urandom), 1'b0, "wide_rand");
        end
    endtask

    initial begin
        clear_masks();
        test_reset();
        test_clean();
        test_stuck_bit();
        test_stuck_word();
        test_hold_start();
        test_async_reset();
        test_random_faults();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
